ring_vc_scheduler: RTL and testbench
====================================

Name: ring_vc_scheduler

Overview:
Per-direction buffering and scheduling controller for one output link of the ring router.
- Owns the virtual-channel slots for one travel direction.
- Allocates incoming link flits and host-injected flits to free VCs.
- Uses round-robin arbitration to pick which VC drives the outgoing link or ejects to the local host.
- Replaces ad-hoc full flags with credit-based flow control in both directions.
- Two instances per router: one rightward, one leftward.

Parameters:
- ROUTER_ID, 0, this router's ring address.
- PACKET_SIZE, 8, flit width; destination field is flit[ROUTER_BITS-1:0].
- ROUTER_BITS, 2, width of the destination field.
- NUM_VC, 4, total VC slots. VC0..NUM_VC-2 are link-only; VC NUM_VC-1 is host-only.
- NUM_CREDITS, 2, downstream buffer credits available at reset.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- link_data_in  in  PACKET_SIZE  flit from upstream router
- link_valid_in  in  1  link flit present this cycle
- credit_out  out  1  one-cycle pulse: one link VC freed, return credit upstream
- host_data_in  in  PACKET_SIZE  host flit already routed to this direction
- host_valid_in  in  1  host flit offered
- host_ready  out  1  host VC free; transfer occurs when host_valid_in & host_ready
- link_data_out  out  PACKET_SIZE  flit to downstream router
- link_valid_out  out  1  link_data_out valid
- credit_in  in  1  one-cycle pulse: downstream freed one buffer
- eject_data  out  PACKET_SIZE  flit delivered to local host
- eject_valid  out  1  eject_data valid
- occupancy  out  $clog2(NUM_VC+1)  count of valid VC slots
- overflow_err  out  1  sticky: link flit arrived with no free link VC

Behaviour:
- **Reset:** all slot valid bits 0; link_data_out, eject_data = 0; link_valid_out, eject_valid, credit_out, overflow_err = 0; credit_cnt = NUM_CREDITS; both RR pointers = 0; occupancy = 0. host_ready = 1 the cycle after reset deasserts.
- **Reset mid-operation:** drops all buffered flits. No credit_out is emitted for dropped flits.
- **Link allocation:** on link_valid_in, the flit is written into the lowest-index free link VC at the clock edge.
  - "Free" is judged on pre-edge state. A slot freed at the same edge is not reusable until the next cycle.
  - If no link VC is free: flit dropped, overflow_err set (sticky until rst).
- **Host allocation:** host_ready = !valid[NUM_VC-1]. Accepted flit is written into VC NUM_VC-1 at the edge.
- **Classification:** a valid slot is an eject candidate if dest == ROUTER_ID, otherwise a forward candidate.
- **Forward arbiter:** round-robin over forward candidates, enabled only when credit_cnt > 0.
  - On grant i, at the edge: link_data_out <= slot i, link_valid_out <= 1, slot i freed, pointer <= (i+1) mod NUM_VC.
  - No grant: link_valid_out <= 0, link_data_out holds its value.
- **Eject arbiter:** independent round-robin with the same rules, driving eject_data/eject_valid. Consumes no credit.
- **Dual grant:** one forward and one eject grant may occur in the same cycle (necessarily from different slots).
- **credit_out:** registered pulse at the edge that frees a link VC (0..NUM_VC-2) by either arbiter. If two link VCs free in the same cycle, pulse on two consecutive cycles, using a 1-entry pending counter.
- **Credit counter:**
  - Forward grant: credit_cnt - 1.
  - credit_in: credit_cnt + 1.
  - Both together: unchanged.
  - Saturates at NUM_CREDITS; an excess credit_in is ignored.
- **Latency:** flit accepted at edge t is eligible in cycle t+1 and visible on the output after edge t+1. Minimum input-to-output latency is 2 cycles.
- **occupancy:** registered popcount of slot valid bits.

Decomposition:
- **Package noc_pkg:** PACKET_SIZE, ROUTER_BITS, flit_t typedef, dest_of(flit) function, HOST_VC index constant.
- **Sub-module rr_arbiter:** parameter NUM_REQ. Inputs req vector, enable; outputs one-hot grant and grant_valid; owns the pointer. Instantiated twice (forward, eject).

Test Plan (ROUTER_ID=1, NUM_VC=4, NUM_CREDITS=2):
1. **Reset:** assert rst 2 cycles, then release → all outputs 0, host_ready=1, occupancy=0.
2. **Single forward:** link flit 0x23 (dest 3) at cycle t0 → link_valid_out=1 with 0x23 in cycle t0+2; credit_out pulse in t0+2; internal credit_cnt=1.
3. **Credit stall:** link flits 0x03, 0x07, 0x0B back-to-back, no credit_in → first two forwarded, third held. credit_in pulse at cycle c → 0x0B on the link in cycle c+2.
4. **Eject:** link flit 0x41 (dest 1) → eject_valid=1 with 0x41 two cycles later; link_valid_out stays 0; credit_cnt unchanged; one credit_out pulse.
5. **Round-robin order:** exhaust credits, then fill VC0..VC2 via link and VC3 via host, all dest 2. Return one credit per cycle → forward order VC0, VC1, VC2, VC3; host_ready returns to 1 after VC3 leaves.
6. **Overflow:** with all three link VCs held (credits 0), a fourth link flit → dropped, overflow_err=1, occupancy stays 3. rst → overflow_err=0, occupancy=0, no credit_out pulses.

Source files
------------

// File: rtl/noc_pkg.sv
// Shared ring-NoC types: flit format, destination extraction and the host VC index.
package noc_pkg;
  localparam int PACKET_SIZE = 8;
  localparam int ROUTER_BITS = 2;
  localparam int NUM_VC      = 4;
  localparam int HOST_VC     = NUM_VC - 1;

  typedef logic [PACKET_SIZE-1:0] flit_t;

  function automatic logic [ROUTER_BITS-1:0] dest_of(input flit_t f);
    return f[ROUTER_BITS-1:0];
  endfunction
endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: combinational one-hot grant starting at the pointer, pointer moves past the winner.
// Zero-latency grant; en low suppresses every grant and freezes the pointer.
module rr_arbiter #(
  parameter  int NUM_REQ = 4,
  localparam int PTR_W   = $clog2(NUM_REQ)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] grant,
  output logic               grant_valid,
  output logic [PTR_W-1:0]   grant_idx
);
  logic [PTR_W-1:0] ptr;
  logic [PTR_W-1:0] cand;

  always_comb begin
    grant       = '0;
    grant_valid = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = PTR_W'((int'(ptr) + i) % NUM_REQ);
      if (en && !grant_valid && req[cand]) begin
        grant_valid = 1'b1;
        grant[cand] = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
    end else if (grant_valid) begin
      ptr <= (int'(grant_idx) == NUM_REQ - 1) ? '0 : grant_idx + PTR_W'(1);
    end
  end
endmodule

// File: rtl/ring_vc_scheduler.sv
// One direction of a ring router output: VC slot allocation, forward/eject round-robin, credit flow control.
// Input-to-output latency 2 cycles; forwarding stalls at zero downstream credits, host stalls while its VC is busy.
module ring_vc_scheduler #(
  parameter int ROUTER_ID   = 0,
  parameter int PACKET_SIZE = noc_pkg::PACKET_SIZE,
  parameter int ROUTER_BITS = noc_pkg::ROUTER_BITS,
  parameter int NUM_VC      = noc_pkg::NUM_VC,
  parameter int NUM_CREDITS = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [PACKET_SIZE-1:0]       link_data_in,
  input  logic                         link_valid_in,
  output logic                         credit_out,
  input  logic [PACKET_SIZE-1:0]       host_data_in,
  input  logic                         host_valid_in,
  output logic                         host_ready,
  output logic [PACKET_SIZE-1:0]       link_data_out,
  output logic                         link_valid_out,
  input  logic                         credit_in,
  output logic [PACKET_SIZE-1:0]       eject_data,
  output logic                         eject_valid,
  output logic [$clog2(NUM_VC+1)-1:0]  occupancy,
  output logic                         overflow_err
);
  localparam int HOST   = NUM_VC - 1;
  localparam int NLINK  = NUM_VC - 1;
  localparam int VC_W   = $clog2(NUM_VC);
  localparam int OCC_W  = $clog2(NUM_VC + 1);
  localparam int CNT_W  = $clog2(NUM_CREDITS + 1);
  localparam int PEND_W = $clog2(NUM_VC + 1);

  logic [NUM_VC-1:0]      valid, valid_n;
  logic [PACKET_SIZE-1:0] slot [NUM_VC];
  logic [NUM_VC-1:0]      fwd_req, ej_req, fwd_gnt, ej_gnt, freed;
  logic                   fwd_gv, ej_gv;
  logic [VC_W-1:0]        fwd_idx, ej_idx, link_vc;
  logic                   link_free, link_wr, host_wr;
  logic [CNT_W-1:0]       credit_cnt;
  logic [PEND_W-1:0]      credit_pend, freed_cnt, pend_total;
  logic [OCC_W-1:0]       occ_n;

  assign host_ready = !valid[HOST];
  assign host_wr    = host_valid_in && host_ready;

  always_comb begin
    fwd_req = '0;
    ej_req  = '0;
    for (int i = 0; i < NUM_VC; i++) begin
      if (slot[i][ROUTER_BITS-1:0] == ROUTER_BITS'(ROUTER_ID)) ej_req[i] = valid[i];
      else                                                      fwd_req[i] = valid[i];
    end
  end

  rr_arbiter #(.NUM_REQ(NUM_VC)) u_fwd_arb (
    .clk(clk), .rst(rst), .en(credit_cnt != '0), .req(fwd_req),
    .grant(fwd_gnt), .grant_valid(fwd_gv), .grant_idx(fwd_idx)
  );

  rr_arbiter #(.NUM_REQ(NUM_VC)) u_ej_arb (
    .clk(clk), .rst(rst), .en(1'b1), .req(ej_req),
    .grant(ej_gnt), .grant_valid(ej_gv), .grant_idx(ej_idx)
  );

  // Free slots are judged on pre-edge valid bits, so a slot granted this cycle is not refilled until the next.
  always_comb begin
    link_free = 1'b0;
    link_vc   = '0;
    for (int i = 0; i < NLINK; i++) begin
      if (!link_free && !valid[i]) begin
        link_free = 1'b1;
        link_vc   = VC_W'(i);
      end
    end
  end
  assign link_wr = link_valid_in && link_free;

  always_comb begin
    freed     = fwd_gnt | ej_gnt;
    valid_n   = valid & ~freed;
    if (link_wr) valid_n[link_vc] = 1'b1;
    if (host_wr) valid_n[HOST] = 1'b1;
    freed_cnt = '0;
    for (int i = 0; i < NLINK; i++) freed_cnt = freed_cnt + PEND_W'(freed[i]);
    pend_total = credit_pend + freed_cnt;
    occ_n = '0;
    for (int i = 0; i < NUM_VC; i++) occ_n = occ_n + OCC_W'(valid_n[i]);
  end

  always_ff @(posedge clk) begin
    if (link_wr) slot[link_vc] <= link_data_in;
    if (host_wr) slot[HOST] <= host_data_in;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid          <= '0;
      link_data_out  <= '0;
      link_valid_out <= 1'b0;
      eject_data     <= '0;
      eject_valid    <= 1'b0;
      credit_out     <= 1'b0;
      credit_pend    <= '0;
      credit_cnt     <= CNT_W'(NUM_CREDITS);
      occupancy      <= '0;
      overflow_err   <= 1'b0;
    end else begin
      valid          <= valid_n;
      link_valid_out <= fwd_gv;
      eject_valid    <= ej_gv;
      if (fwd_gv) link_data_out <= slot[fwd_idx];
      if (ej_gv)  eject_data    <= slot[ej_idx];
      // Two link VCs freed together spill one credit return into the following cycle.
      credit_out  <= (pend_total != '0);
      credit_pend <= (pend_total != '0) ? pend_total - PEND_W'(1) : '0;
      if (fwd_gv && !credit_in) begin
        credit_cnt <= credit_cnt - CNT_W'(1);
      end else if (credit_in && !fwd_gv && credit_cnt < CNT_W'(NUM_CREDITS)) begin
        credit_cnt <= credit_cnt + CNT_W'(1);
      end
      occupancy    <= occ_n;
      overflow_err <= overflow_err | (link_valid_in & ~link_free);
    end
  end
endmodule

// File: tb/tb_ring_vc_scheduler.sv
// Directed bench for ring_vc_scheduler at ROUTER_ID=1, NUM_VC=4, NUM_CREDITS=2.
module tb_ring_vc_scheduler;
  import noc_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  flit_t      link_data_in = '0;
  logic       link_valid_in = 1'b0;
  logic       credit_out;
  flit_t      host_data_in = '0;
  logic       host_valid_in = 1'b0;
  logic       host_ready;
  flit_t      link_data_out;
  logic       link_valid_out;
  logic       credit_in = 1'b0;
  flit_t      eject_data;
  logic       eject_valid;
  logic [2:0] occupancy;
  logic       overflow_err;

  int checks = 0;
  int passes = 0;

  ring_vc_scheduler #(
    .ROUTER_ID(1), .PACKET_SIZE(8), .ROUTER_BITS(2), .NUM_VC(4), .NUM_CREDITS(2)
  ) dut (
    .clk(clk), .rst(rst),
    .link_data_in(link_data_in), .link_valid_in(link_valid_in), .credit_out(credit_out),
    .host_data_in(host_data_in), .host_valid_in(host_valid_in), .host_ready(host_ready),
    .link_data_out(link_data_out), .link_valid_out(link_valid_out), .credit_in(credit_in),
    .eject_data(eject_data), .eject_valid(eject_valid),
    .occupancy(occupancy), .overflow_err(overflow_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1);
  end

  initial begin
    // Reset
    step(); step();
    rst = 1'b0;
    step();
    check("rst_lvo",  32'(link_valid_out), 0);
    check("rst_ldo",  32'(link_data_out), 0);
    check("rst_ejv",  32'(eject_valid), 0);
    check("rst_ejd",  32'(eject_data), 0);
    check("rst_cout", 32'(credit_out), 0);
    check("rst_ovf",  32'(overflow_err), 0);
    check("rst_occ",  32'(occupancy), 0);
    check("rst_hrdy", 32'(host_ready), 1);
    check("rst_cnt",  32'(dut.credit_cnt), 2);

    // Dual grant: eject from VC0 and forward from host VC in the same cycle
    link_valid_in = 1'b1; link_data_in = 8'h21;
    host_valid_in = 1'b1; host_data_in = 8'h22;
    step();
    link_valid_in = 1'b0; host_valid_in = 1'b0;
    check("dual_occ", 32'(occupancy), 2);
    step();
    check("dual_ejv",  32'(eject_valid), 1);
    check("dual_ejd",  32'(eject_data), 32'h21);
    check("dual_lvo",  32'(link_valid_out), 1);
    check("dual_ldo",  32'(link_data_out), 32'h22);
    check("dual_cout", 32'(credit_out), 1);
    credit_in = 1'b1; step(); credit_in = 1'b0;
    check("dual_cnt", 32'(dut.credit_cnt), 2);

    // Single forward
    link_valid_in = 1'b1; link_data_in = 8'h23;
    step();
    link_valid_in = 1'b0;
    check("fwd_occ1", 32'(occupancy), 1);
    check("fwd_lvo1", 32'(link_valid_out), 0);
    step();
    check("fwd_lvo",  32'(link_valid_out), 1);
    check("fwd_ldo",  32'(link_data_out), 32'h23);
    check("fwd_cout", 32'(credit_out), 1);
    check("fwd_cnt",  32'(dut.credit_cnt), 1);
    check("fwd_occ2", 32'(occupancy), 0);
    step();
    check("fwd_lvo_off", 32'(link_valid_out), 0);
    check("fwd_ldo_hold", 32'(link_data_out), 32'h23);
    check("fwd_cout_off", 32'(credit_out), 0);
    credit_in = 1'b1; step(); credit_in = 1'b0;
    check("fwd_cnt_ret", 32'(dut.credit_cnt), 2);

    // Credit stall
    link_valid_in = 1'b1; link_data_in = 8'h03; step();
    link_data_in = 8'h07; step();
    check("stall_ldo0", 32'(link_data_out), 32'h03);
    check("stall_lvo0", 32'(link_valid_out), 1);
    link_data_in = 8'h0B; step();
    link_valid_in = 1'b0;
    check("stall_ldo1", 32'(link_data_out), 32'h07);
    check("stall_cnt0", 32'(dut.credit_cnt), 0);
    step();
    check("stall_lvo_held", 32'(link_valid_out), 0);
    check("stall_occ", 32'(occupancy), 1);
    step();
    check("stall_lvo_held2", 32'(link_valid_out), 0);
    credit_in = 1'b1; step(); credit_in = 1'b0;
    check("stall_lvo_c1", 32'(link_valid_out), 0);
    step();
    check("stall_lvo_c2", 32'(link_valid_out), 1);
    check("stall_ldo_c2", 32'(link_data_out), 32'h0B);
    credit_in = 1'b1; step(); step(); step(); credit_in = 1'b0;
    check("credit_sat", 32'(dut.credit_cnt), 2);

    // Eject
    link_valid_in = 1'b1; link_data_in = 8'h41; step();
    link_valid_in = 1'b0; step();
    check("ej_ejv",  32'(eject_valid), 1);
    check("ej_ejd",  32'(eject_data), 32'h41);
    check("ej_lvo",  32'(link_valid_out), 0);
    check("ej_cnt",  32'(dut.credit_cnt), 2);
    check("ej_cout", 32'(credit_out), 1);
    step();
    check("ej_ejv_off",  32'(eject_valid), 0);
    check("ej_cout_off", 32'(credit_out), 0);

    // Exhaust credits through the host VC (no credit_out for host VC)
    check("host_rdy0", 32'(host_ready), 1);
    host_valid_in = 1'b1; host_data_in = 8'h33; step();
    host_valid_in = 1'b0;
    check("host_rdy_busy", 32'(host_ready), 0);
    step();
    check("host_ldo0", 32'(link_data_out), 32'h33);
    check("host_cout", 32'(credit_out), 0);
    check("host_rdy1", 32'(host_ready), 1);
    host_valid_in = 1'b1; host_data_in = 8'h37; step();
    host_valid_in = 1'b0; step();
    check("host_ldo1", 32'(link_data_out), 32'h37);
    check("host_cnt0", 32'(dut.credit_cnt), 0);

    // Round-robin order across all four VCs
    link_valid_in = 1'b1; link_data_in = 8'h02;
    host_valid_in = 1'b1; host_data_in = 8'h0E; step();
    host_valid_in = 1'b0;
    link_data_in = 8'h06; step();
    link_data_in = 8'h0A; step();
    link_valid_in = 1'b0;
    check("rr_occ", 32'(occupancy), 4);
    check("rr_hrdy0", 32'(host_ready), 0);
    credit_in = 1'b1; step(); step();
    check("rr_vc0", 32'(link_data_out), 32'h02);
    check("rr_cout0", 32'(credit_out), 1);
    step();
    check("rr_vc1", 32'(link_data_out), 32'h06);
    step();
    credit_in = 1'b0;
    check("rr_vc2", 32'(link_data_out), 32'h0A);
    check("rr_hrdy1", 32'(host_ready), 0);
    step();
    check("rr_vc3", 32'(link_data_out), 32'h0E);
    check("rr_lvo3", 32'(link_valid_out), 1);
    check("rr_hrdy2", 32'(host_ready), 1);
    check("rr_cnt", 32'(dut.credit_cnt), 0);

    // Overflow with all link VCs held
    link_valid_in = 1'b1; link_data_in = 8'h12; step();
    link_data_in = 8'h16; step();
    link_data_in = 8'h1A; step();
    check("ovf_pre", 32'(overflow_err), 0);
    link_data_in = 8'h1E; step();
    link_valid_in = 1'b0;
    check("ovf_set", 32'(overflow_err), 1);
    check("ovf_occ", 32'(occupancy), 3);
    step();
    check("ovf_sticky", 32'(overflow_err), 1);
    rst = 1'b1; step(); step(); rst = 1'b0;
    check("ovf_rst", 32'(overflow_err), 0);
    check("ovf_rst_occ", 32'(occupancy), 0);
    check("ovf_rst_hrdy", 32'(host_ready), 1);
    for (int i = 0; i < 3; i++) begin
      step();
      check("ovf_no_cout", 32'(credit_out), 0);
      check("ovf_no_lvo", 32'(link_valid_out), 0);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
